// File: rtl/me_pkg.sv
// Shared slot encoding, mode/state enums and the multiplier command type
// for the modular-exponentiation ladder controller.
package me_pkg;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_R0  = 2'd0;
  localparam slot_t SLOT_R1  = 2'd1;
  localparam slot_t SLOT_ONE = 2'd2;

  typedef enum logic {
    MODE_SAM    = 1'b0,
    MODE_LADDER = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    STEP_A,
    STEP_B,
    CONV,
    DONE
  } state_e;

  typedef struct packed {
    slot_t dst;
    slot_t src_a;
    slot_t src_b;
  } mm_cmd_t;

  function automatic mm_cmd_t mk_cmd(input slot_t dst, input slot_t src_a, input slot_t src_b);
    mk_cmd = '{dst: dst, src_a: src_a, src_b: src_b};
  endfunction

endpackage

// File: rtl/me_exp_buf.sv
// Exponent register: written one word at a time while loading, read one bit
// at a time by the controller's bit index.
module me_exp_buf #(
  parameter int K       = 128,
  parameter int E_WORDS = 32,
  parameter int WI_W    = 5,
  parameter int BI_W    = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [WI_W-1:0] i_wr_idx,
  input  logic [K-1:0]    i_wr_word,
  input  logic [BI_W-1:0] i_rd_idx,
  output logic            o_rd_bit
);

  localparam int E_BITS = K * E_WORDS;

  logic [E_BITS-1:0] r_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp <= '0;
    end else if (i_wr_en) begin
      r_exp[i_wr_idx*K +: K] <= i_wr_word;
    end
  end

  assign o_rd_bit = r_exp[i_rd_idx];

endmodule

// File: rtl/me_ladder_ctrl.sv
// Exponent scheduler: loads a word-serial exponent and issues Montgomery
// multiply commands (square-and-multiply or constant-time ladder).
module me_ladder_ctrl
  import me_pkg::*;
#(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int E_WORDS = 32,
  parameter int CNT_W   = $clog2(2*K*E_WORDS+2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             me_start,
  input  logic             me_mode,
  input  logic             me_skip_lz,
  input  logic [K-1:0]     exp_word,
  input  logic             exp_valid,
  output logic             exp_ready,
  output logic             mm_req,
  output logic [1:0]       mm_dst,
  output logic [1:0]       mm_src_a,
  output logic [1:0]       mm_src_b,
  input  logic             mm_ack,
  output logic             me_busy,
  output logic             me_done,
  output logic [CNT_W-1:0] op_count,
  output logic             err_ack
);

  localparam int E_BITS = K * E_WORDS;
  localparam int BI_W   = $clog2(E_BITS);
  localparam int WI_W   = (E_WORDS > 1) ? $clog2(E_WORDS) : 1;
  localparam logic [BI_W-1:0] BIT_TOP   = BI_W'(E_BITS - 1);
  localparam logic [WI_W-1:0] WORD_LAST = WI_W'(E_WORDS - 1);

  if (N < 1 || K < 1 || E_WORDS < 1) begin : g_param_check
    $error("me_ladder_ctrl: K, N and E_WORDS must be positive");
  end

  state_e           r_state, w_next;
  mode_e            r_mode;
  logic             r_skip;
  logic             r_wait;
  logic             r_err_ack;
  logic [WI_W-1:0]  r_word_idx;
  logic [BI_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0] r_op_count;
  logic             w_bit, w_start, w_load_wr, w_last_word;
  logic             w_ack_done, w_idx_zero, w_step_end, w_dec, w_req;
  mm_cmd_t          w_cmd;

  assign w_start     = (r_state == IDLE) && me_start;
  assign w_load_wr   = (r_state == LOAD) && exp_valid;
  assign w_last_word = (r_word_idx == WORD_LAST);
  assign w_ack_done  = r_wait && mm_ack;
  assign w_idx_zero  = (r_bit_idx == '0);
  assign w_step_end  = w_ack_done && ((r_state == STEP_B) ||
                       (r_state == STEP_A && r_mode == MODE_SAM && !w_bit));
  assign w_dec       = !w_idx_zero && (w_step_end || (r_state == SCAN && !w_bit));

  me_exp_buf #(.K(K), .E_WORDS(E_WORDS), .WI_W(WI_W), .BI_W(BI_W)) u_exp_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_load_wr),
    .i_wr_idx  (r_word_idx),
    .i_wr_word (exp_word),
    .i_rd_idx  (r_bit_idx),
    .o_rd_bit  (w_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (me_start) w_next = LOAD;
      LOAD:   if (exp_valid && w_last_word) w_next = r_skip ? SCAN : STEP_A;
      SCAN: begin
        if (w_bit)           w_next = STEP_A;
        else if (w_idx_zero) w_next = CONV;
      end
      STEP_A: begin
        if (w_ack_done) begin
          if (r_mode == MODE_SAM && !w_bit) w_next = w_idx_zero ? CONV : STEP_A;
          else                              w_next = STEP_B;
        end
      end
      STEP_B: if (w_ack_done) w_next = w_idx_zero ? CONV : STEP_A;
      CONV:   if (w_ack_done) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Each step state launches exactly one request on entry, then waits for its ack.
  always_comb begin
    w_req = 1'b0;
    w_cmd = '0;
    case (r_state)
      STEP_A: begin
        w_req = !r_wait;
        if (r_mode == MODE_SAM) w_cmd = mk_cmd(SLOT_R0, SLOT_R0, SLOT_R0);
        else if (w_bit)         w_cmd = mk_cmd(SLOT_R0, SLOT_R0, SLOT_R1);
        else                    w_cmd = mk_cmd(SLOT_R1, SLOT_R0, SLOT_R1);
      end
      STEP_B: begin
        w_req = !r_wait;
        if (r_mode == MODE_SAM) w_cmd = mk_cmd(SLOT_R0, SLOT_R0, SLOT_R1);
        else if (w_bit)         w_cmd = mk_cmd(SLOT_R1, SLOT_R1, SLOT_R1);
        else                    w_cmd = mk_cmd(SLOT_R0, SLOT_R0, SLOT_R0);
      end
      CONV: begin
        w_req = !r_wait;
        w_cmd = mk_cmd(SLOT_R0, SLOT_R0, SLOT_ONE);
      end
      default: ;
    endcase
    if (!w_req) w_cmd = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= MODE_SAM;
      r_skip     <= 1'b0;
      r_wait     <= 1'b0;
      r_err_ack  <= 1'b0;
      r_word_idx <= '0;
      r_bit_idx  <= '0;
      r_op_count <= '0;
    end else begin
      if (w_start) begin
        r_mode     <= mode_e'(me_mode);
        r_skip     <= me_skip_lz & ~me_mode;
        r_op_count <= '0;
        r_word_idx <= '0;
      end else if (w_req) begin
        r_op_count <= r_op_count + 1'b1;
      end
      if (w_load_wr) begin
        r_word_idx <= r_word_idx + 1'b1;
        if (w_last_word) r_bit_idx <= BIT_TOP;
      end
      if (w_dec) r_bit_idx <= r_bit_idx - 1'b1;
      if (w_req)           r_wait <= 1'b1;
      else if (w_ack_done) r_wait <= 1'b0;
      // An ack with nothing outstanding (including one in the launch cycle) wins over the start clear.
      if (w_start) r_err_ack <= 1'b0;
      if (mm_ack && !r_wait) r_err_ack <= 1'b1;
    end
  end

  assign exp_ready = (r_state == LOAD);
  assign me_busy   = (r_state != IDLE) && (r_state != DONE);
  assign me_done   = (r_state == DONE);
  assign mm_req    = w_req;
  assign mm_dst    = w_cmd.dst;
  assign mm_src_a  = w_cmd.src_a;
  assign mm_src_b  = w_cmd.src_b;
  assign op_count  = r_op_count;
  assign err_ack   = r_err_ack;

endmodule

// File: tb/tb_me_ladder_ctrl.sv
// Bench for me_ladder_ctrl: exponent-level op sequence model plus a Montgomery
// operand bank whose R0 is compared with x^e mod m after every run.
module tb_me_ladder_ctrl;

  localparam int K       = 8;
  localparam int E_WORDS = 2;
  localparam int E_BITS  = K * E_WORDS;
  localparam int CNT_W   = $clog2(2*E_BITS+2);
  localparam longint MODULUS = 61603;
  localparam longint R_MONT  = 65536 % MODULUS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             meStart = 1'b0;
  logic             meMode = 1'b0;
  logic             meSkipLz = 1'b0;
  logic [K-1:0]     expWord = '0;
  logic             expValid = 1'b0;
  logic             expReady;
  logic             mmReq;
  logic [1:0]       mmDst, mmSrcA, mmSrcB;
  logic             mmAck;
  logic             meBusy, meDone, errAck;
  logic [CNT_W-1:0] opCount;

  logic       modelAck = 1'b0;
  logic       injectAck = 1'b0;
  int         ackCountdown = 0;
  int         opsSeen = 0;
  int         checkCount = 0;
  int         failCount = 0;
  longint     bank [4];
  longint     rInv = 0;
  logic [5:0] expOps [$];

  assign mmAck = modelAck | injectAck;

  always #5 clk = ~clk;

  me_ladder_ctrl #(.K(K), .N(2), .E_WORDS(E_WORDS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .me_start   (meStart),
    .me_mode    (meMode),
    .me_skip_lz (meSkipLz),
    .exp_word   (expWord),
    .exp_valid  (expValid),
    .exp_ready  (expReady),
    .mm_req     (mmReq),
    .mm_dst     (mmDst),
    .mm_src_a   (mmSrcA),
    .mm_src_b   (mmSrcB),
    .mm_ack     (mmAck),
    .me_busy    (meBusy),
    .me_done    (meDone),
    .op_count   (opCount),
    .err_ack    (errAck)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic longint mont(input longint a, input longint b);
    return (((a * b) % MODULUS) * rInv) % MODULUS;
  endfunction

  function automatic longint powMod(input longint x, input logic [15:0] e);
    longint result = 1;
    for (int i = 0; i < int'(e); i++) result = (result * x) % MODULUS;
    return result;
  endfunction

  // Expected command list straight from the exponent bits: {dst, src_a, src_b}.
  function automatic void buildOps(input logic mode, input logic skip, input logic [15:0] e);
    int top = E_BITS - 1;
    expOps.delete();
    if (skip && !mode) begin
      while (top >= 0 && !e[top]) top--;
    end
    for (int i = top; i >= 0; i--) begin
      if (!mode) begin
        expOps.push_back({2'd0, 2'd0, 2'd0});
        if (e[i]) expOps.push_back({2'd0, 2'd0, 2'd1});
      end else if (e[i]) begin
        expOps.push_back({2'd0, 2'd0, 2'd1});
        expOps.push_back({2'd1, 2'd1, 2'd1});
      end else begin
        expOps.push_back({2'd1, 2'd0, 2'd1});
        expOps.push_back({2'd0, 2'd0, 2'd0});
      end
    end
    expOps.push_back({2'd0, 2'd0, 2'd2});
  endfunction

  // Multiplier model: captures each request, updates the bank, acks 3 cycles later.
  task automatic modelTick();
    logic [5:0] cmd;
    logic [5:0] want;
    cmd = {mmDst, mmSrcA, mmSrcB};
    modelAck = 1'b0;
    if (ackCountdown > 0) begin
      ackCountdown--;
      if (ackCountdown == 0) modelAck = 1'b1;
    end
    if (mmReq) begin
      opsSeen++;
      want = (expOps.size() > 0) ? expOps.pop_front() : 6'h3F;
      checkOutput("opCmd", 64'(cmd), 64'(want));
      bank[mmDst] = mont(bank[mmSrcA], bank[mmSrcB]);
      ackCountdown = 3;
    end else begin
      checkOutput("cmdIdle", 64'(cmd), 64'd0);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    modelTick();
  endtask

  task automatic applyStimulus(input logic mode, input logic skip, input logic [15:0] e,
                               input bit injectStart, input bit abortRun, output int finalCount);
    int     w, cyc, donePulses, wantCount, opsBase;
    bit     injected;
    longint x;
    buildOps(mode, skip, e);
    wantCount = expOps.size();
    x = longint'($urandom_range(2, 60000));
    bank[0] = R_MONT;
    bank[1] = (x * R_MONT) % MODULUS;
    bank[2] = 1;
    bank[3] = 0;
    opsBase = opsSeen;
    finalCount = -1;
    meMode = mode;
    meSkipLz = skip;
    meStart = 1'b1;
    stepCycle();
    meStart = 1'b0;
    checkOutput("loadReady", 64'(expReady), 64'd1);
    checkOutput("loadBusy", 64'(meBusy), 64'd1);
    checkOutput("loadCount", 64'(opCount), 64'd0);
    checkOutput("loadErrAck", 64'(errAck), 64'd0);
    w = 0;
    while (w < E_WORDS) begin
      expValid = ($urandom_range(0, 2) != 0);
      expWord = e[K*w +: K];
      stepCycle();
      if (expValid) w++;
    end
    injected = 1'b0;
    donePulses = 0;
    cyc = 0;
    while (cyc < 3000 && donePulses == 0) begin
      expValid = 1'($urandom_range(0, 1));
      expWord = K'($urandom);
      meStart = injectStart && !injected && (opsSeen - opsBase) >= 1;
      if (meStart) injected = 1'b1;
      if (abortRun && (opsSeen - opsBase) >= 2) begin
        meStart = 1'b0;
        expValid = 1'b0;
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("rstReq", 64'(mmReq), 64'd0);
        checkOutput("rstBusy", 64'(meBusy), 64'd0);
        checkOutput("rstDone", 64'(meDone), 64'd0);
        checkOutput("rstReady", 64'(expReady), 64'd0);
        checkOutput("rstCount", 64'(opCount), 64'd0);
        checkOutput("rstErrAck", 64'(errAck), 64'd0);
        finalCount = int'(opCount);
        return;
      end
      stepCycle();
      cyc++;
      if (meDone) begin
        donePulses++;
        checkOutput("doneBusy", 64'(meBusy), 64'd0);
        checkOutput("doneReady", 64'(expReady), 64'd0);
        checkOutput("opCount", 64'(opCount), 64'(wantCount));
        checkOutput("opsLeft", 64'(expOps.size()), 64'd0);
        checkOutput("bankR0", 64'(bank[0]), 64'(powMod(x, e)));
        finalCount = int'(opCount);
      end
    end
    meStart = 1'b0;
    expValid = 1'b0;
    checkOutput("doneSeen", 64'(donePulses), 64'd1);
    stepCycle();
    checkOutput("donePulse", 64'(meDone), 64'd0);
    checkOutput("idleBusy", 64'(meBusy), 64'd0);
  endtask

  initial begin
    int cnt;
    logic [15:0] e;
    for (longint r = 1; r < MODULUS; r++) begin
      if ((R_MONT * r) % MODULUS == 1) begin
        rInv = r;
        break;
      end
    end
    repeat (3) stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("resetReq", 64'(mmReq), 64'd0);
    checkOutput("resetBusy", 64'(meBusy), 64'd0);
    checkOutput("resetDone", 64'(meDone), 64'd0);
    checkOutput("resetReady", 64'(expReady), 64'd0);
    checkOutput("resetCount", 64'(opCount), 64'd0);
    checkOutput("resetErrAck", 64'(errAck), 64'd0);

    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, cnt);
    checkOutput("planSamCount", 64'(cnt), 64'd6);
    applyStimulus(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, cnt);
    checkOutput("planLadderCount", 64'(cnt), 64'd33);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, cnt);
    checkOutput("planZeroCount", 64'(cnt), 64'd1);

    injectAck = 1'b1;
    stepCycle();
    injectAck = 1'b0;
    stepCycle();
    checkOutput("errAckSpurious", 64'(errAck), 64'd1);
    applyStimulus(1'b1, 1'b0, 16'hB3C5, 1'b1, 1'b0, cnt);
    checkOutput("planStartIgnored", 64'(cnt), 64'd33);

    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, cnt);
    stepCycle();
    stepCycle();
    checkOutput("errAckAfterRst", 64'(errAck), 64'd1);
    applyStimulus(1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, cnt);
    checkOutput("planAfterRstCount", 64'(cnt), 64'd18);

    for (int t = 0; t < 8; t++) begin
      e = 16'($urandom) >> $urandom_range(0, 15);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, 1'b0, 1'b0, cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
